uart_tx_output: RTL

UART_TX_OUTPUT -- requirements
Module: uart_tx_output

---
 rtl/uart_tx_output_pkg.sv | 15 +
 rtl/uart_tx_output_fifo.sv | 52 +++++
 rtl/uart_tx_output.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_tx_output_pkg.sv
// Shared constants for the UART transmit path: IO word width, default
// baud divisor, frame geometry and the transmitter FSM state encoding.
package uart_tx_output_pkg;

  localparam int WORD_SIZE         = 16;
  localparam int UART_CLKS_PER_BIT = 16;
  localparam int UART_FRAME_BITS   = 10;
  localparam int UART_DATA_BITS    = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

endpackage

// File: rtl/uart_tx_output_fifo.sv
// sync_fifo: small synchronous FIFO with a combinational head word.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; a pop on an empty FIFO is ignored.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_output.sv
// uart_tx_output: buffers bytes written by the IO decoder and sends them
// as 8N1 frames on tx. Frames are back-to-back while words are queued.
module uart_tx_output
  import uart_tx_output_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 out_write,
  input  logic [WORD_SIZE-1:0] io_out,
  output logic                 tx,
  output logic                 busy,
  output logic                 full,
  output logic                 overflow
);

  logic [1:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_full;
  logic        baud_done;
  logic        pop;
  logic        unused_hi_bits;

  assign unused_hi_bits = ^io_out[WORD_SIZE-1:8];

  assign baud_done = (baud_cnt == 16'(CLKS_PER_BIT - 1));
  // Pop from IDLE, or at the last STOP cycle to chain the next frame
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_STOP) && baud_done));

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .areset (areset),
    .push   (out_write),
    .pop    (pop),
    .din    (io_out[7:0]),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign busy = (state != ST_IDLE) || !fifo_empty;
  assign full = fifo_full;

  // Frame sequencer: registered tx, baud and bit counters
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          if (pop) begin
            state <= ST_START;
            tx    <= 1'b0;
          end
        end
        ST_START: begin
          if (baud_done) begin
            state    <= ST_DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              tx      <= shreg[bit_cnt + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (pop) begin
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

  // Shift register loads the head word whenever a frame is launched
  always_ff @(posedge clk) begin
    if (pop) shreg <= fifo_dout;
  end

  // Sticky overflow: write refused because the FIFO is full and not draining
  always_ff @(posedge clk or negedge areset) begin
    if (!areset)                                 overflow <= 1'b0;
    else if (out_write && fifo_full && !pop)     overflow <= 1'b1;
  end

endmodule
